// File: rtl/local_mem_responder_if.sv
// Memory-bus bundle between the execute unit (master) and the local RAM responder (slave).
// Requests are held by the master until the matching done pulse.
interface local_mem_responder_if #(
   parameter int RV = 32,
   parameter int VA = RV
) ();
   logic [VA-1:RV/16] addr;
   logic [VA-1:1]     pc;
   logic              ifetch;
   logic [1:0]        rstrobe;
   logic [RV/8-1:0]   wmask;
   logic [RV-1:0]     wdata;
   logic              io_access;
   logic              idone;
   logic              rdone;
   logic              wdone;
   logic [RV-1:0]     rdata;
   logic [15:0]       idata;
   logic              bus_err;

   modport master (
      output addr, pc, ifetch, rstrobe, wmask, wdata, io_access,
      input  idone, rdone, wdone, rdata, idata, bus_err
   );

   modport slave (
      input  addr, pc, ifetch, rstrobe, wmask, wdata, io_access,
      output idone, rdone, wdone, rdata, idata, bus_err
   );
endinterface

// File: rtl/local_mem_responder.sv
// Services fetch/load/store requests from a byte-writable local RAM with WAIT
// wait states; one registered done pulse per request, bus_err outside the RAM window.
module local_mem_responder #(
   parameter int RV   = 32,
   parameter int VA   = RV,
   parameter int AW   = 10,
   parameter int WAIT = 1
) (
   input logic                  clk,
   input logic                  reset_n,
   local_mem_responder_if.slave bus
);
   localparam int LB = RV / 16;
   localparam int WA = VA - LB;
   localparam int NB = RV / 8;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_e;
   typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_e;

   logic [RV-1:0] mem [2**AW];

   state_e          state_q, state_d;
   kind_e           kind_q, kind_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [WA-1:0]   waddr_q, waddr_d;
   logic            hsel_q, hsel_d;
   logic [NB-1:0]   mask_q, mask_d;
   logic [RV-1:0]   wdat_q, wdat_d;
   logic [1:0]      rsel_q, rsel_d;
   logic            idone_q, idone_d;
   logic            rdone_q, rdone_d;
   logic            wdone_q, wdone_d;
   logic            err_q, err_d;
   logic [RV-1:0]   rdata_q, rdata_d;
   logic [15:0]     idata_q, idata_d;

   logic            st_req, ld_req, in_rng, mem_we;
   logic [AW-1:0]   idx;
   logic [RV-1:0]   rd_word;

   // IO-space data requests belong to the IO fabric; only a fetch survives io_access.
   assign st_req  = (|bus.wmask) & ~bus.io_access;
   assign ld_req  = (|bus.rstrobe) & ~bus.io_access;
   assign idx     = waddr_q[AW-1:0];
   assign in_rng  = (waddr_q >> AW) == '0;
   assign rd_word = mem[idx];

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      cnt_d   = cnt_q;
      waddr_d = waddr_q;
      hsel_d  = hsel_q;
      mask_d  = mask_q;
      wdat_d  = wdat_q;
      rsel_d  = rsel_q;
      idone_d = 1'b0;
      rdone_d = 1'b0;
      wdone_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      idata_d = idata_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (st_req || ld_req || bus.ifetch) begin
               cnt_d   = 4'(WAIT);
               state_d = (WAIT > 0) ? S_WAIT : S_ACCESS;
               mask_d  = bus.wmask;
               wdat_d  = bus.wdata;
               rsel_d  = bus.rstrobe;
               hsel_d  = (RV == 32) ? bus.pc[1] : 1'b0;
               if (st_req) begin
                  kind_d  = K_STORE;
                  waddr_d = bus.addr;
               end else if (ld_req) begin
                  kind_d  = K_LOAD;
                  waddr_d = bus.addr;
               end else begin
                  kind_d  = K_FETCH;
                  waddr_d = bus.pc[VA-1:LB];
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_ACCESS;
         end
         S_ACCESS: begin
            state_d = S_DONE;
            err_d   = ~in_rng;
            case (kind_q)
               K_STORE: begin
                  wdone_d = 1'b1;
                  mem_we  = in_rng;
               end
               K_LOAD: begin
                  rdone_d = 1'b1;
                  if (!in_rng)               rdata_d = '0;
                  else if (rsel_q == 2'b11)  rdata_d = rd_word;
                  else if (rsel_q == 2'b10)  rdata_d = RV'(rd_word[15:8]);
                  else                       rdata_d = RV'(rd_word[7:0]);
               end
               default: begin
                  idone_d = 1'b1;
                  idata_d = in_rng ? 16'(rd_word >> (hsel_q ? 16 : 0)) : 16'h0;
               end
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         kind_q  <= K_FETCH;
         cnt_q   <= '0;
         waddr_q <= '0;
         hsel_q  <= 1'b0;
         mask_q  <= '0;
         wdat_q  <= '0;
         rsel_q  <= '0;
         idone_q <= 1'b0;
         rdone_q <= 1'b0;
         wdone_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         idata_q <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         cnt_q   <= cnt_d;
         waddr_q <= waddr_d;
         hsel_q  <= hsel_d;
         mask_q  <= mask_d;
         wdat_q  <= wdat_d;
         rsel_q  <= rsel_d;
         idone_q <= idone_d;
         rdone_q <= rdone_d;
         wdone_q <= wdone_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         idata_q <= idata_d;
      end
   end

   // RAM is never cleared by reset; writes only happen from the ACCESS state.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++)
            if (mask_q[i]) mem[idx][8*i +: 8] <= wdat_q[8*i +: 8];
      end
   end

   assign bus.idone   = idone_q;
   assign bus.rdone   = rdone_q;
   assign bus.wdone   = wdone_q;
   assign bus.bus_err = err_q;
   assign bus.rdata   = rdata_q;
   assign bus.idata   = idata_q;
endmodule

// File: tb/tb_local_mem_responder.sv
// Self-checking bench for local_mem_responder: directed scenarios plus random traffic
// checked against a word-array memory model.
module tb_local_mem_responder;
   localparam int RV = 32, VA = 32, AW = 10, WAIT = 1;
   localparam int LAT = WAIT + 2;
   localparam int WIN = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   local_mem_responder_if #(.RV(RV), .VA(VA)) bus ();
   local_mem_responder #(.RV(RV), .VA(VA), .AW(AW), .WAIT(WAIT)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int nchk = 0, nerr = 0;
   int cyc_w, cyc_r, cyc_i, n_w, n_r, n_i;
   logic err_w, err_r, err_i;
   logic [31:0] cap_rdata, end_rdata;
   logic [15:0] cap_idata;
   logic [31:0] mdl [0:1023];

   task automatic clear_bus();
      bus.addr = '0; bus.pc = '0; bus.ifetch = 1'b0; bus.rstrobe = 2'b00;
      bus.wmask = '0; bus.wdata = '0; bus.io_access = 1'b0;
   endtask

   // Drive a request set at a negedge, watch WIN cycles, drop each line on its own done.
   task automatic txn(input logic [3:0] wm, input logic [31:0] wd, input logic [1:0] rs,
                      input logic ifc, input logic io, input int a, input int p);
      bus.wmask = wm; bus.wdata = wd; bus.rstrobe = rs; bus.ifetch = ifc;
      bus.io_access = io; bus.addr = 30'(a); bus.pc = 31'(p);
      cyc_w = -1; cyc_r = -1; cyc_i = -1; n_w = 0; n_r = 0; n_i = 0;
      err_w = 1'b0; err_r = 1'b0; err_i = 1'b0;
      for (int c = 1; c <= WIN; c++) begin
         @(negedge clk);
         if (bus.wdone) begin
            n_w++; if (cyc_w < 0) cyc_w = c; err_w = bus.bus_err; bus.wmask = '0;
         end
         if (bus.rdone) begin
            n_r++; if (cyc_r < 0) cyc_r = c; err_r = bus.bus_err; cap_rdata = bus.rdata;
            bus.rstrobe = 2'b00;
         end
         if (bus.idone) begin
            n_i++; if (cyc_i < 0) cyc_i = c; err_i = bus.bus_err; cap_idata = bus.idata;
            bus.ifetch = 1'b0;
         end
      end
      end_rdata = bus.rdata;
      clear_bus();
   endtask

   function automatic void mdl_store(input int w, input logic [3:0] wm, input logic [31:0] wd);
      for (int i = 0; i < 4; i++) if (wm[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
   endfunction

   function automatic logic [31:0] mdl_load(input int w, input logic [1:0] rs);
      if (rs == 2'b11) return mdl[w];
      return (mdl[w] >> (8 * (rs - 1))) & 32'hFF;
   endfunction

   function automatic logic [15:0] mdl_fetch(input int h);
      return 16'(mdl[h / 2] >> (16 * (h % 2)));
   endfunction

   task automatic test_reset();
      clear_bus();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      nchk++; if ({bus.idone, bus.rdone, bus.wdone, bus.bus_err} !== 4'b0) begin
         nerr++; $display("FAIL rst_done: got %b want 0000", {bus.idone, bus.rdone, bus.wdone, bus.bus_err}); end
      nchk++; if (bus.rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
      nchk++; if (bus.idata !== 16'h0) begin nerr++; $display("FAIL rst_idata: got %h want 0", bus.idata); end
      reset_n = 1'b1;
      // Request presented in the very first cycle after release.
      txn(4'hF, 32'h12345678, 2'b00, 1'b0, 1'b0, 5, 0);
      mdl_store(5, 4'hF, 32'h12345678);
      nchk++; if (cyc_w !== LAT || n_w !== 1) begin
         nerr++; $display("FAIL first_store: got cyc %0d n %0d want cyc %0d n 1", cyc_w, n_w, LAT); end
      nchk++; if (err_w !== 1'b0 || n_r + n_i !== 0) begin
         nerr++; $display("FAIL first_store_err: got err %b others %0d want 0 0", err_w, n_r + n_i); end
   endtask

   task automatic test_basic();
      txn(4'h0, 32'h0, 2'b11, 1'b0, 1'b0, 5, 0);
      nchk++; if (cap_rdata !== 32'h12345678 || cyc_r !== LAT || n_r !== 1 || err_r !== 1'b0) begin
         nerr++; $display("FAIL ld_full: got %h cyc %0d n %0d err %b want 12345678 cyc %0d n 1 err 0",
                          cap_rdata, cyc_r, n_r, err_r, LAT); end
      txn(4'b0100, 32'hAAAAAAAA, 2'b00, 1'b0, 1'b0, 5, 0);
      mdl_store(5, 4'b0100, 32'hAAAAAAAA);
      txn(4'h0, 32'h0, 2'b11, 1'b0, 1'b0, 5, 0);
      nchk++; if (cap_rdata !== 32'h12AA5678) begin nerr++; $display("FAIL ld_merge: got %h want 12aa5678", cap_rdata); end
      txn(4'h0, 32'h0, 2'b10, 1'b0, 1'b0, 5, 0);
      nchk++; if (cap_rdata !== 32'h00000056) begin nerr++; $display("FAIL ld_byte1: got %h want 00000056", cap_rdata); end
      txn(4'h0, 32'h0, 2'b00, 1'b1, 1'b0, 0, 11);
      nchk++; if (cap_idata !== 16'h12AA || cyc_i !== LAT || n_i !== 1) begin
         nerr++; $display("FAIL fetch_hi: got %h cyc %0d n %0d want 12aa cyc %0d n 1", cap_idata, cyc_i, n_i, LAT); end
      nchk++; if (end_rdata !== 32'h00000056) begin nerr++; $display("FAIL rdata_hold: got %h want 00000056", end_rdata); end
      txn(4'h0, 32'h0, 2'b00, 1'b1, 1'b0, 0, 10);
      nchk++; if (cap_idata !== 16'h5678) begin nerr++; $display("FAIL fetch_lo: got %h want 5678", cap_idata); end
   endtask

   task automatic test_priority();
      txn(4'h0, 32'h0, 2'b11, 1'b1, 1'b0, 5, 10);
      nchk++; if (cyc_r !== LAT || cyc_i !== LAT + WAIT + 3 || n_r !== 1 || n_i !== 1) begin
         nerr++; $display("FAIL ld_then_if: got r %0d i %0d n %0d/%0d want r %0d i %0d n 1/1",
                          cyc_r, cyc_i, n_r, n_i, LAT, LAT + WAIT + 3); end
      // Store first, then the load sees the fresh data, then the fetch.
      txn(4'b0001, 32'h99999999, 2'b01, 1'b1, 1'b0, 5, 10);
      mdl_store(5, 4'b0001, 32'h99999999);
      nchk++; if (cyc_w !== LAT || cyc_r !== LAT + WAIT + 3 || cyc_i !== LAT + 2 * (WAIT + 3)) begin
         nerr++; $display("FAIL st_ld_if_order: got w %0d r %0d i %0d want %0d %0d %0d",
                          cyc_w, cyc_r, cyc_i, LAT, LAT + WAIT + 3, LAT + 2 * (WAIT + 3)); end
      nchk++; if (cap_rdata !== mdl_load(5, 2'b01) || cap_idata !== mdl_fetch(10)) begin
         nerr++; $display("FAIL st_ld_if_data: got %h/%h want %h/%h", cap_rdata, cap_idata, mdl_load(5, 2'b01), mdl_fetch(10)); end
      txn(4'hF, 32'hDEADBEEF, 2'b11, 1'b1, 1'b1, 5, 11);
      nchk++; if (n_w !== 0 || n_r !== 0 || n_i !== 1 || cyc_i !== LAT) begin
         nerr++; $display("FAIL io_access: got w %0d r %0d i %0d cyc %0d want 0 0 1 cyc %0d", n_w, n_r, n_i, cyc_i, LAT); end
      txn(4'h0, 32'h0, 2'b11, 1'b0, 1'b0, 5, 0);
      nchk++; if (cap_rdata !== mdl[5]) begin nerr++; $display("FAIL io_nowrite: got %h want %h", cap_rdata, mdl[5]); end
   endtask

   task automatic test_fill();
      for (int w = 0; w < 16; w++) begin
         logic [31:0] d;
         if (w == 5) continue;
         d = $urandom;
         txn(4'hF, d, 2'b00, 1'b0, 1'b0, w, 0);
         mdl_store(w, 4'hF, d);
         nchk++; if (n_w !== 1 || cyc_w !== LAT) begin
            nerr++; $display("FAIL fill_%0d: got n %0d cyc %0d want 1 %0d", w, n_w, cyc_w, LAT); end
      end
   endtask

   task automatic test_range();
      txn(4'h0, 32'h0, 2'b11, 1'b0, 1'b0, 1 << AW, 0);
      nchk++; if (n_r !== 1 || err_r !== 1'b1 || cap_rdata !== 32'h0) begin
         nerr++; $display("FAIL oor_load: got n %0d err %b data %h want 1 1 0", n_r, err_r, cap_rdata); end
      txn(4'hF, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b0, (1 << AW) + 3, 0);
      nchk++; if (n_w !== 1 || err_w !== 1'b1) begin
         nerr++; $display("FAIL oor_store: got n %0d err %b want 1 1", n_w, err_w); end
      txn(4'h0, 32'h0, 2'b11, 1'b0, 1'b0, 3, 0);
      nchk++; if (cap_rdata !== mdl[3] || err_r !== 1'b0) begin
         nerr++; $display("FAIL oor_alias: got %h err %b want %h 0", cap_rdata, err_r, mdl[3]); end
      txn(4'h0, 32'h0, 2'b00, 1'b1, 1'b0, 0, (1 << AW) * 2 + 1);
      nchk++; if (n_i !== 1 || err_i !== 1'b1 || cap_idata !== 16'h0) begin
         nerr++; $display("FAIL oor_fetch: got n %0d err %b data %h want 1 1 0", n_i, err_i, cap_idata); end
      txn(4'h0, 32'h0, 2'b11, 1'b0, 1'b0, (1 << AW) - 1, 0);
      nchk++; if (n_r !== 1 || err_r !== 1'b0) begin
         nerr++; $display("FAIL top_word: got n %0d err %b want 1 0", n_r, err_r); end
   endtask

   task automatic test_reset_mid();
      int nw = 0;
      bus.wmask = 4'hF; bus.wdata = 32'h0BADF00D; bus.addr = 30'(9);
      @(negedge clk);
      reset_n = 1'b0;
      clear_bus();
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.wdone) nw++;
      end
      nchk++; if (nw !== 0) begin nerr++; $display("FAIL rst_mid_done: got %0d want 0", nw); end
      txn(4'h0, 32'h0, 2'b11, 1'b0, 1'b0, 9, 0);
      nchk++; if (cap_rdata !== mdl[9]) begin nerr++; $display("FAIL rst_mid_word: got %h want %h", cap_rdata, mdl[9]); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++) begin
         int op, w, h;
         logic [3:0] wm;
         logic [31:0] wd;
         logic [1:0] rs;
         logic io;
         op = $urandom_range(0, 2);
         w  = $urandom_range(0, 15);
         if (op == 0) begin
            wm = 4'($urandom_range(1, 15)); wd = $urandom;
            txn(wm, wd, 2'b00, 1'b0, 1'b0, w, 0);
            mdl_store(w, wm, wd);
            nchk++; if (n_w !== 1 || cyc_w !== LAT || err_w !== 1'b0) begin
               nerr++; $display("FAIL rnd_st: got n %0d cyc %0d err %b want 1 %0d 0", n_w, cyc_w, err_w, LAT); end
         end else if (op == 1) begin
            rs = 2'($urandom_range(1, 3)); io = ($urandom_range(0, 4) == 0);
            txn(4'h0, 32'h0, rs, 1'b0, io, w, 0);
            nchk++;
            if (io) begin
               if (n_r !== 0) begin nerr++; $display("FAIL rnd_io: got n %0d want 0", n_r); end
            end else if (n_r !== 1 || cap_rdata !== mdl_load(w, rs)) begin
               nerr++; $display("FAIL rnd_ld: w %0d rs %b got %h n %0d want %h n 1", w, rs, cap_rdata, n_r, mdl_load(w, rs));
            end
         end else begin
            h = w * 2 + $urandom_range(0, 1);
            txn(4'h0, 32'h0, 2'b00, 1'b1, 1'b0, 0, h);
            nchk++; if (n_i !== 1 || cap_idata !== mdl_fetch(h)) begin
               nerr++; $display("FAIL rnd_if: h %0d got %h n %0d want %h n 1", h, cap_idata, n_i, mdl_fetch(h)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_fill();
      test_range();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
